// File: rtl/spiral_color_stage.sv
// Ring-index to VGA colour stage with a per-frame animated phase and LAT-deep sync/de alignment.
// Optional SPIRAL_HILITE_EN paints the ring whose index equals the phase white.
module spiral_color_stage #(
  parameter int   LAT      = 3,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] r_sqroot,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic [1:0] speed,
  input  logic       dir,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic [5:0] rgb
);

  // Stage k holds the input delayed by k cycles; stage LAT drives the outputs.
  logic [LAT:1] hs_dly;
  logic [LAT:1] vs_dly;
  logic [LAT:1] de_dly;

  logic       vs_prev;
  logic [2:0] fcnt;
  logic [3:0] phase;
  logic [2:0] mask;
  logic       tick;
  logic       step;
  logic [3:0] idx;

  function automatic logic [5:0] pal(input logic [3:0] i);
    case (i)
      4'h0: pal = 6'h30;
      4'h1: pal = 6'h34;
      4'h2: pal = 6'h38;
      4'h3: pal = 6'h3C;
      4'h4: pal = 6'h2C;
      4'h5: pal = 6'h1C;
      4'h6: pal = 6'h0C;
      4'h7: pal = 6'h0D;
      4'h8: pal = 6'h0E;
      4'h9: pal = 6'h0F;
      4'hA: pal = 6'h0B;
      4'hB: pal = 6'h07;
      4'hC: pal = 6'h03;
      4'hD: pal = 6'h13;
      4'hE: pal = 6'h23;
      default: pal = 6'h33;
    endcase
  endfunction

  always_comb begin
    mask = 3'b000;
    case (speed)
      2'd1:    mask = 3'b011;
      2'd2:    mask = 3'b001;
      default: mask = 3'b000;
    endcase
  end

  assign tick = (vsync_in == SYNC_POL) && (vs_prev != SYNC_POL);
  // Mask tests the count before this tick's increment.
  assign step = tick && (speed != 2'd0) && ((fcnt & mask) == 3'b000);
  assign idx  = r_sqroot + phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_dly  <= {LAT{~SYNC_POL}};
      vs_dly  <= {LAT{~SYNC_POL}};
      de_dly  <= '0;
      vs_prev <= ~SYNC_POL;
      fcnt    <= 3'd0;
      phase   <= 4'd0;
      rgb     <= 6'h00;
    end else begin
      hs_dly  <= {hs_dly[LAT-1:1], hsync_in};
      vs_dly  <= {vs_dly[LAT-1:1], vsync_in};
      de_dly  <= {de_dly[LAT-1:1], de_in};
      vs_prev <= vsync_in;
      if (tick)
        fcnt <= fcnt + 3'd1;
      if (step)
        phase <= dir ? phase + 4'd1 : phase - 4'd1;
      // de aligned with r_sqroot sits at stage LAT-1.
      if (!de_dly[LAT-1])
        rgb <= 6'h00;
`ifdef SPIRAL_HILITE_EN
      else if (r_sqroot == phase)
        rgb <= 6'h3F;
`endif
      else
        rgb <= pal(idx);
    end
  end

  assign hsync_out = hs_dly[LAT];
  assign vsync_out = vs_dly[LAT];
  assign de_out    = de_dly[LAT];

endmodule
